source_pipelined: RTL and testbench

- Next-generation HCI-style load streamer.
- Takes a stream of byte addresses and issues up to MAX_OUTSTANDING TCDM reads without waiting for the consumer.
- Realigns each response by its byte offset, buffers it in an internal response FIFO and emits a fixed-length output stream.
- Sits between an address generator and an engine datapath. Unlike the previous streamer, consumer backpressure never stalls an accepted response, and the block tracks transaction count and completion.

---
 rtl/source_pipelined.sv | 238 +++++++++++++++++++++++
 tb/tb_source_pipelined.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/source_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : source_pipelined
// Brief    : Pipelined TCDM load streamer with credit-limited outstanding reads,
//            byte-offset realignment (`SRC_MISALIGNED_EN) and response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module source_pipelined #(
  parameter int DATA_WIDTH      = 32,
`ifdef SRC_MISALIGNED_EN
  parameter int TCDM_DW         = DATA_WIDTH + 32,
`else
  parameter int TCDM_DW         = DATA_WIDTH,
`endif
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TRANS_CNT       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [TRANS_CNT-1:0]    len_i,
  output logic                    ready_start_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  input  logic                    addr_valid_i,
  input  logic [ADDR_WIDTH-1:0]   addr_data_i,
  output logic                    addr_ready_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [TCDM_DW/8-1:0]    tcdm_be_o,
  input  logic                    tcdm_r_valid_i,
  input  logic [TCDM_DW-1:0]      tcdm_r_data_i,
  output logic                    tcdm_r_ready_o,
  output logic                    stream_valid_o,
  output logic [DATA_WIDTH-1:0]   stream_data_o,
  input  logic                    stream_ready_i
);

  localparam int c_PW = $clog2(MAX_OUTSTANDING);
  localparam int c_CW = c_PW + 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [TRANS_CNT-1:0] c_T_ONE = TRANS_CNT'(1);
  localparam logic [c_PW-1:0]      c_P_ONE = c_PW'(1);
  localparam logic [c_CW-1:0]      c_C_ONE = c_CW'(1);
  localparam logic [c_CW:0]        c_D_ONE = (c_CW+1)'(1);
  localparam logic [c_CW:0]        c_MAX   = (c_CW+1)'(MAX_OUTSTANDING);

`ifdef SRC_MISALIGNED_EN
  if (TCDM_DW != DATA_WIDTH + 32) begin : g_tcdm_dw_check
    $error("source_pipelined: TCDM_DW must equal DATA_WIDTH+32 with realignment");
  end
`else
  if (TCDM_DW != DATA_WIDTH) begin : g_tcdm_dw_check
    $error("source_pipelined: TCDM_DW must equal DATA_WIDTH without realignment");
  end
`endif
  if ((DATA_WIDTH % 32) != 0) begin : g_dw_check
    $error("source_pipelined: DATA_WIDTH must be a multiple of 32");
  end
  if ((MAX_OUTSTANDING < 2) || ((1 << c_PW) != MAX_OUTSTANDING)) begin : g_mo_check
    $error("source_pipelined: MAX_OUTSTANDING must be a power of 2 and >= 2");
  end

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [TRANS_CNT-1:0]  r_len;
  logic [TRANS_CNT-1:0]  r_req_cnt;
  logic [TRANS_CNT-1:0]  r_out_cnt;
  logic [TRANS_CNT-1:0]  w_req_cnt_inc;
  logic [c_CW-1:0]       r_inflight;
  logic [c_CW:0]         r_drop;
  logic [c_CW:0]         w_drop_load;
  logic                  r_err;
  logic                  r_zero_done;

  logic [DATA_WIDTH-1:0] r_rf_mem [MAX_OUTSTANDING];
  logic [c_PW-1:0]       r_rf_wr;
  logic [c_PW-1:0]       r_rf_rd;
  logic [c_CW-1:0]       r_rf_cnt;

  logic                  w_start;
  logic                  w_grant;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_rsp_drop;
  logic                  w_rsp_spur;
  logic                  w_rsp_take;
  logic [DATA_WIDTH-1:0] w_rsp_word;

  assign w_start       = (r_state == c_IDLE) && start_i;
  assign w_grant       = tcdm_req_o && tcdm_gnt_i;
  assign w_pop         = stream_valid_o && stream_ready_i;
  assign w_credit      = ({1'b0, r_inflight} + {1'b0, r_rf_cnt}) < c_MAX;
  assign w_req_cnt_inc = r_req_cnt + c_T_ONE;

  // Responses owed to a cleared run are swallowed before anything else.
  assign w_rsp_drop = tcdm_r_valid_i && (r_drop != '0);
  assign w_rsp_spur = tcdm_r_valid_i && (r_drop == '0) && (r_inflight == '0);
  assign w_rsp_take = tcdm_r_valid_i && (r_drop == '0) && (r_inflight != '0);

  assign addr_ready_o   = w_grant;
  assign tcdm_add_o     = {addr_data_i[ADDR_WIDTH-1:2], 2'b00};
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = '0;
  assign tcdm_r_ready_o = 1'b1;
  assign err_o          = r_err;
  assign stream_valid_o = (r_rf_cnt != '0);
  assign stream_data_o  = r_rf_mem[r_rf_rd];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) r_state <= c_IDLE;
    else                  r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (start_i && (len_i != '0)) w_state_next = c_RUN;
      c_RUN:   if (w_grant && (w_req_cnt_inc == r_len)) w_state_next = c_DRAIN;
      c_DRAIN: if (r_out_cnt == r_len) w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    ready_start_o = (r_state == c_IDLE);
    busy_o        = (r_state == c_RUN) || (r_state == c_DRAIN);
    done_o        = r_zero_done || ((r_state == c_DRAIN) && (r_out_cnt == r_len));
    tcdm_req_o    = (r_state == c_RUN) && addr_valid_i && (r_req_cnt < r_len) && w_credit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_len       <= '0;
      r_req_cnt   <= '0;
      r_out_cnt   <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_start && (len_i == '0);
      if (w_start) begin
        r_len     <= len_i;
        r_req_cnt <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_grant) r_req_cnt <= w_req_cnt_inc;
        if (w_pop)   r_out_cnt <= r_out_cnt + c_T_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_inflight <= '0;
    end else begin
      case ({w_grant, w_rsp_take})
        2'b10:   r_inflight <= r_inflight + c_C_ONE;
        2'b01:   r_inflight <= r_inflight - c_C_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // On clear, remember every response still owed by memory so it can be discarded.
  assign w_drop_load = r_drop + {1'b0, r_inflight}
                     + (w_grant ? c_D_ONE : '0)
                     - ((w_rsp_drop || w_rsp_take) ? c_D_ONE : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i)           r_drop <= '0;
    else if (clear_i)    r_drop <= w_drop_load;
    else if (w_rsp_drop) r_drop <= r_drop - c_D_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) r_err <= 1'b0;
    else if (w_rsp_spur)  r_err <= 1'b1;
  end

`ifdef SRC_MISALIGNED_EN
  logic [1:0]      r_off_mem [MAX_OUTSTANDING];
  logic [c_PW-1:0] r_off_wr;
  logic [c_PW-1:0] r_off_rd;
  logic [1:0]      w_off;

  always_ff @(posedge clk_i) begin
    if (w_grant) r_off_mem[r_off_wr] <= addr_data_i[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_off_wr <= '0;
      r_off_rd <= '0;
    end else begin
      if (w_grant)    r_off_wr <= r_off_wr + c_P_ONE;
      if (w_rsp_take) r_off_rd <= r_off_rd + c_P_ONE;
    end
  end

  assign w_off      = r_off_mem[r_off_rd];
  assign w_rsp_word = tcdm_r_data_i[{w_off, 3'b000} +: DATA_WIDTH];
`else
  logic w_unused_offset;
  assign w_unused_offset = ^addr_data_i[1:0];
  assign w_rsp_word      = tcdm_r_data_i[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (w_rsp_take) r_rf_mem[r_rf_wr] <= w_rsp_word;
  end

  // Credit accounting keeps a take on a full FIFO paired with a pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_rf_wr  <= '0;
      r_rf_rd  <= '0;
      r_rf_cnt <= '0;
    end else begin
      if (w_rsp_take) r_rf_wr <= r_rf_wr + c_P_ONE;
      if (w_pop)      r_rf_rd <= r_rf_rd + c_P_ONE;
      case ({w_rsp_take, w_pop})
        2'b10:   r_rf_cnt <= r_rf_cnt + c_C_ONE;
        2'b01:   r_rf_cnt <= r_rf_cnt - c_C_ONE;
        default: r_rf_cnt <= r_rf_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_source_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_source_pipelined
// Brief    : Scoreboard bench for source_pipelined (honours `SRC_MISALIGNED_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_source_pipelined;

  localparam int DW   = 32;
`ifdef SRC_MISALIGNED_EN
  localparam int TDW  = DW + 32;
`else
  localparam int TDW  = DW;
`endif
  localparam int AW   = 32;
  localparam int MAXO = 4;
  localparam int TC   = 16;

  logic            clk_i = 1'b0;
  logic            rst_i, clear_i, start_i;
  logic [TC-1:0]   len_i;
  logic            ready_start_o, busy_o, done_o, err_o;
  logic            addr_valid_i;
  logic [AW-1:0]   addr_data_i;
  logic            addr_ready_o;
  logic            tcdm_req_o, tcdm_gnt_i;
  logic [AW-1:0]   tcdm_add_o;
  logic            tcdm_wen_o;
  logic [TDW/8-1:0] tcdm_be_o;
  logic            tcdm_r_valid_i;
  logic [TDW-1:0]  tcdm_r_data_i;
  logic            tcdm_r_ready_o;
  logic            stream_valid_o;
  logic [DW-1:0]   stream_data_o;
  logic            stream_ready_i;

  always #5 clk_i = ~clk_i;

  source_pipelined #(
    .DATA_WIDTH(DW), .TCDM_DW(TDW), .ADDR_WIDTH(AW),
    .MAX_OUTSTANDING(MAXO), .TRANS_CNT(TC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
    .ready_start_o(ready_start_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .addr_valid_i(addr_valid_i), .addr_data_i(addr_data_i), .addr_ready_o(addr_ready_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_ready_o(tcdm_r_ready_o),
    .stream_valid_o(stream_valid_o), .stream_data_o(stream_data_o),
    .stream_ready_i(stream_ready_i)
  );

  typedef struct {
    logic [TDW-1:0] data;
    int             due;
  } rsp_t;

  int n_pass = 0, n_total = 0, cyc = 0;
  rsp_t          mem_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_src[$];
  int            aidx;

  int p_gnt, p_ready, p_aval, p_rsp, lat_max;
  bit mem_hold = 0, spur = 0, force_en = 0;
  logic [TDW-1:0] force_data;

  int n_grants, n_beats, n_done, n_req_cyc, n_valid_cyc;
  int first_grant_cyc, last_grant_cyc, first_beat_cyc;
  bit last_req;
  logic [DW-1:0] last_beat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [TDW-1:0] rnd_word();
    logic [TDW-1:0] w;
    for (int i = 0; i < TDW / 32; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  // Reference: the beat is the memory word shifted down by the byte offset.
  function automatic logic [DW-1:0] realign(input logic [TDW-1:0] d, input logic [1:0] off);
    logic [TDW-1:0] s;
`ifdef SRC_MISALIGNED_EN
    s = d >> (8 * int'(off));
`else
    s = d;
    if (off == 2'b00) s = d;
`endif
    return s[DW-1:0];
  endfunction

  task automatic drive();
    tcdm_gnt_i     = ($urandom_range(99) < p_gnt);
    stream_ready_i = ($urandom_range(99) < p_ready);
    addr_valid_i   = (aidx < addr_src.size()) && ($urandom_range(99) < p_aval);
    addr_data_i    = (aidx < addr_src.size()) ? addr_src[aidx] : $urandom();
    if (spur) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = rnd_word();
    end else if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc &&
                 $urandom_range(99) < p_rsp) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      tcdm_r_valid_i = 1'b0;
      tcdm_r_data_i  = rnd_word();
    end
  endtask

  task automatic observe();
    rsp_t r;
    last_req = tcdm_req_o;
    if (tcdm_req_o) n_req_cyc++;
    if (done_o) n_done++;
    if (tcdm_req_o && tcdm_gnt_i) begin
      chk("tcdm_add", 64'(tcdm_add_o), 64'({addr_data_i[AW-1:2], 2'b00}));
      chk("addr_ready", 64'(addr_ready_o), 64'd1);
      r.data = force_en ? force_data : rnd_word();
      r.due  = cyc + 1 + int'($urandom_range(lat_max));
      mem_q.push_back(r);
      exp_q.push_back(realign(r.data, addr_data_i[1:0]));
      aidx++;
      n_grants++;
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
      last_grant_cyc = cyc;
      chk("credit_limit", 64'((n_grants - n_beats) <= MAXO), 64'd1);
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk_i);
    observe();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic start_run(input int len);
    n_grants = 0; n_beats = 0; n_done = 0; n_req_cyc = 0; n_valid_cyc = 0;
    first_grant_cyc = -1; last_grant_cyc = -1; first_beat_cyc = -1;
    aidx = 0;
    start_i = 1'b1;
    len_i   = TC'(len);
    tick();
    start_i = 1'b0;
    len_i   = TC'($urandom());
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_done_seen"}, 64'(n_done != 0), 64'd1);
  endtask

  // Monitor: pops the scoreboard whenever a beat is accepted.
  always @(negedge clk_i) begin
    logic [DW-1:0] e;
    if (!rst_i && !clear_i && stream_valid_o) begin
      n_valid_cyc++;
      if (stream_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(stream_data_o), 64'hx);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(stream_data_o), 64'(e));
        end
        n_beats++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat = stream_data_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
    addr_valid_i = 1'b0; addr_data_i = '0; tcdm_gnt_i = 1'b0;
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0; stream_ready_i = 1'b0;
    p_gnt = 100; p_ready = 100; p_aval = 100; p_rsp = 100; lat_max = 0;
    aidx = 0; force_data = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    chk("rst_ready_start", 64'(ready_start_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_stream_valid", 64'(stream_valid_o), 64'd0);
    chk("rst_tcdm_req", 64'(tcdm_req_o), 64'd0);

    // Aligned run of four beats; a fifth address must stay unconsumed.
    addr_src.delete();
    for (int i = 0; i < 5; i++) addr_src.push_back(AW'(4 * i));
    start_run(4);
    wait_done(50, "A");
    chk("A_grants", 64'(n_grants), 64'd4);
    chk("A_addr_consumed", 64'(aidx), 64'd4);
    chk("A_back_to_back", 64'(last_grant_cyc - first_grant_cyc), 64'd3);
    chk("A_req_cycles", 64'(n_req_cyc), 64'd4);
    chk("A_latency", 64'(first_beat_cyc - first_grant_cyc), 64'd2);
    chk("A_beats", 64'(n_beats), 64'd4);
    repeat (3) tick();
    chk("A_done_pulses", 64'(n_done), 64'd1);
    chk("A_ready_start", 64'(ready_start_o), 64'd1);
    chk("A_busy", 64'(busy_o), 64'd0);

    // Consumer stalled: credits cap the requests at MAX_OUTSTANDING.
    p_ready = 0;
    addr_src.delete();
    for (int i = 0; i < 8; i++) addr_src.push_back(AW'(32'h200 + 4 * i));
    start_run(8);
    repeat (12) tick();
    chk("B_grants_capped", 64'(n_grants), 64'(MAXO));
    chk("B_req_low", 64'(last_req), 64'd0);
    chk("B_no_beats", 64'(n_beats), 64'd0);
    p_ready = 100;
    wait_done(100, "B");
    chk("B_grants", 64'(n_grants), 64'd8);
    chk("B_beats", 64'(n_beats), 64'd8);
    chk("B_exp_empty", 64'(exp_q.size()), 64'd0);

`ifdef SRC_MISALIGNED_EN
    force_en   = 1'b1;
    force_data = {32'h44332211, 32'hAABBCCDD};
    addr_src.delete();
    addr_src.push_back(32'h101);
    start_run(1);
    wait_done(50, "C");
    chk("C_realign", 64'(last_beat), 64'h11AABBCC);
    force_en = 1'b0;
`endif

    // Zero-length start.
    addr_src.delete();
    addr_src.push_back(32'h40);
    start_run(0);
    chk("D_done_not_same_cycle", 64'(n_done), 64'd0);
    tick();
    chk("D_done_next_cycle", 64'(n_done), 64'd1);
    repeat (3) tick();
    chk("D_single_pulse", 64'(n_done), 64'd1);
    chk("D_no_req", 64'(n_req_cyc), 64'd0);
    chk("D_ready_start", 64'(ready_start_o), 64'd1);

    // Spurious response with nothing outstanding.
    addr_src.delete();
    n_valid_cyc = 0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (3) tick();
    chk("E_err_set", 64'(err_o), 64'd1);
    chk("E_no_valid", 64'(n_valid_cyc), 64'd0);
    repeat (5) tick();
    chk("E_err_sticky", 64'(err_o), 64'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("E_err_cleared", 64'(err_o), 64'd0);

    // Clear with three reads in flight; their late responses must vanish.
    mem_hold = 1'b1;
    addr_src.delete();
    for (int i = 0; i < 3; i++) addr_src.push_back(AW'(32'h300 + 4 * i));
    start_run(8);
    for (int k = 0; k < 20 && n_grants < 3; k++) tick();
    repeat (2) tick();
    chk("F_three_inflight", 64'(n_grants), 64'd3);
    clear_i = 1'b1;
    exp_q.delete();
    tick();
    clear_i = 1'b0;
    mem_hold = 1'b0;
    n_valid_cyc = 0;
    repeat (10) tick();
    chk("F_drained", 64'(mem_q.size()), 64'd0);
    chk("F_no_beats", 64'(n_valid_cyc), 64'd0);
    chk("F_err", 64'(err_o), 64'd0);
    chk("F_idle", 64'(ready_start_o), 64'd1);
    addr_src.delete();
    for (int i = 0; i < 2; i++) addr_src.push_back(AW'(32'h400 + 4 * i));
    start_run(2);
    wait_done(50, "F");
    chk("F_beats", 64'(n_beats), 64'd2);
    chk("F_exp_empty", 64'(exp_q.size()), 64'd0);

    // Randomised runs: random handshakes, latency and addresses.
    for (int r = 0; r < 6; r++) begin
      int len;
      p_gnt   = int'($urandom_range(30, 100));
      p_ready = int'($urandom_range(20, 100));
      p_aval  = int'($urandom_range(50, 100));
      p_rsp   = int'($urandom_range(50, 100));
      lat_max = int'($urandom_range(0, 3));
      len     = int'($urandom_range(1, 24));
      addr_src.delete();
      for (int i = 0; i < len + 2; i++) addr_src.push_back(AW'($urandom()));
      start_run(len);
      wait_done(3000, "R");
      chk("R_beats", 64'(n_beats), 64'(len));
      chk("R_exp_empty", 64'(exp_q.size()), 64'd0);
      chk("R_err", 64'(err_o), 64'd0);
      repeat (2) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
